// File: rtl/operand_fetch.sv
// Register-read stage between decode and execute: reads up to two operands,
// forwards same-cycle writebacks and stalls on RAW/WAW through a scoreboard.
module operand_fetch (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1023:0] gr_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [4:0]    rs1_i,
  input  logic [4:0]    rs2_i,
  input  logic          rs1_en_i,
  input  logic          rs2_en_i,
  input  logic [4:0]    rd_i,
  input  logic [4:0]    rd2_i,
  input  logic          rd_en_i,
  input  logic          rd2_en_i,
  input  logic          wb_en_i,
  input  logic          wb2_en_i,
  input  logic [4:0]    wb_dest_i,
  input  logic [4:0]    wb2_dest_i,
  input  logic [31:0]   wb_data_i,
  input  logic [31:0]   wb2_data_i,
  input  logic          flush_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [31:0]   op1_o,
  output logic [31:0]   op2_o,
  output logic [4:0]    out_rd_o,
  output logic [4:0]    out_rd2_o,
  output logic          out_rd_en_o,
  output logic          out_rd2_en_o
);

  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic [31:0] out_dst_mask;
  logic [31:0] retiring;
  logic [31:0] busy;
  logic [31:0] blocked;
  logic        hazard;
  logic        accept;
  logic        handoff;
  logic [31:0] op1_sel;
  logic [31:0] op2_sel;

  // Port 2 overrides port 1 so a dual write to one register reads the later value.
  function automatic logic [31:0] select_operand(
    input logic [4:0]    idx,
    input logic          en,
    input logic [1023:0] regs,
    input logic          hit1,
    input logic [31:0]   data1,
    input logic          hit2,
    input logic [31:0]   data2
  );
    logic [31:0] value;
    value = '0;
    if (!en || idx == 5'd0) begin
      value = '0;
    end else if (hit2) begin
      value = data2;
    end else if (hit1) begin
      value = data1;
    end else begin
      value = regs[{idx, 5'd0} +: 32];
    end
    return value;
  endfunction

  always_comb begin
    out_dst_mask = '0;
    if (out_valid_o && out_rd_en_o) out_dst_mask[out_rd_o] = 1'b1;
    if (out_valid_o && out_rd2_en_o) out_dst_mask[out_rd2_o] = 1'b1;
  end

  always_comb begin
    retiring = '0;
    if (wb_en_i) retiring[wb_dest_i] = 1'b1;
    if (wb2_en_i) retiring[wb2_dest_i] = 1'b1;
  end

  // A register stops blocking only once it is pending and retiring this cycle;
  // the instruction still sitting in the output register always blocks.
  always_comb begin
    busy       = pending | out_dst_mask;
    blocked    = busy & ~(pending & retiring);
    blocked[0] = 1'b0;
  end

  always_comb begin
    hazard = 1'b0;
    if (rs1_en_i && blocked[rs1_i]) hazard = 1'b1;
    if (rs2_en_i && blocked[rs2_i]) hazard = 1'b1;
    if (rd_en_i && blocked[rd_i]) hazard = 1'b1;
    if (rd2_en_i && blocked[rd2_i]) hazard = 1'b1;
  end

  assign in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign handoff    = out_valid_o && out_ready_i && !flush_i;

  // Set wins over clear when the same register both retires and is handed off.
  always_comb begin
    pending_nxt    = pending & ~retiring;
    if (handoff) pending_nxt = pending_nxt | out_dst_mask;
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    op1_sel = select_operand(rs1_i, rs1_en_i, gr_i,
                             wb_en_i && wb_dest_i == rs1_i, wb_data_i,
                             wb2_en_i && wb2_dest_i == rs1_i, wb2_data_i);
    op2_sel = select_operand(rs2_i, rs2_en_i, gr_i,
                             wb_en_i && wb_dest_i == rs2_i, wb_data_i,
                             wb2_en_i && wb2_dest_i == rs2_i, wb2_data_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_o  <= 1'b0;
      op1_o        <= '0;
      op2_o        <= '0;
      out_rd_o     <= '0;
      out_rd2_o    <= '0;
      out_rd_en_o  <= 1'b0;
      out_rd2_en_o <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o  <= 1'b1;
      op1_o        <= op1_sel;
      op2_o        <= op2_sel;
      out_rd_o     <= rd_i;
      out_rd2_o    <= rd2_i;
      out_rd_en_o  <= rd_en_i;
      out_rd2_en_o <= rd2_en_i;
    end else if (handoff) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch; expected output records are queued at issue
// and compared by an independent monitor whenever the stage presents a result.
module tb_operand_fetch;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic [4:0]  rd2;
    logic        rd_en;
    logic        rd2_en;
  } rec_t;

  logic          clk;
  logic          rst_n;
  logic [1023:0] gr_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [4:0]    rs1_i, rs2_i, rd_i, rd2_i;
  logic          rs1_en_i, rs2_en_i, rd_en_i, rd2_en_i;
  logic          wb_en_i, wb2_en_i;
  logic [4:0]    wb_dest_i, wb2_dest_i;
  logic [31:0]   wb_data_i, wb2_data_i;
  logic          flush_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [31:0]   op1_o, op2_o;
  logic [4:0]    out_rd_o, out_rd2_o;
  logic          out_rd_en_o, out_rd2_en_o;

  logic [31:0] gr_mem [32];
  rec_t        exp_q [$];
  int          checks;
  int          failures;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n), .gr_i(gr_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rs1_en_i(rs1_en_i), .rs2_en_i(rs2_en_i),
    .rd_i(rd_i), .rd2_i(rd2_i), .rd_en_i(rd_en_i), .rd2_en_i(rd2_en_i),
    .wb_en_i(wb_en_i), .wb2_en_i(wb2_en_i),
    .wb_dest_i(wb_dest_i), .wb2_dest_i(wb2_dest_i),
    .wb_data_i(wb_data_i), .wb2_data_i(wb2_data_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .op1_o(op1_o), .op2_o(op2_o),
    .out_rd_o(out_rd_o), .out_rd2_o(out_rd2_o),
    .out_rd_en_o(out_rd_en_o), .out_rd2_en_o(out_rd2_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: the writeback stage commits port 1 then port 2.
  always @(posedge clk) begin
    if (wb_en_i && wb_dest_i != 5'd0) gr_mem[wb_dest_i] <= wb_data_i;
    if (wb2_en_i && wb2_dest_i != 5'd0) gr_mem[wb2_dest_i] <= wb2_data_i;
  end

  always_comb begin
    gr_i = '0;
    for (int r = 0; r < 32; r++) gr_i[r*32 +: 32] = gr_mem[r];
  end

  task automatic checkOutput(input string name, input logic [75:0] actual, input logic [75:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Monitor: every presented result is compared against the queue head; a flushed
  // result is dropped, a held one is re-compared each cycle to prove stability.
  rec_t got_rec;
  always @(negedge clk) begin
    if (rst_n && out_valid_o) begin
      got_rec = '{op1: op1_o, op2: op2_o, rd: out_rd_o, rd2: out_rd2_o,
                  rd_en: out_rd_en_o, rd2_en: out_rd2_en_o};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output actual=%h expected=none", got_rec);
      end else if (flush_i) begin
        void'(exp_q.pop_front());
      end else begin
        checkOutput("out_record", got_rec, exp_q[0]);
        if (out_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic setWb(input logic en1, input logic [4:0] d1, input logic [31:0] v1,
                       input logic en2, input logic [4:0] d2, input logic [31:0] v2);
    wb_en_i = en1; wb_dest_i = d1; wb_data_i = v1;
    wb2_en_i = en2; wb2_dest_i = d2; wb2_data_i = v2;
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic rs1_en,
                               input logic [4:0] rs2, input logic rs2_en,
                               input logic [4:0] rd, input logic rd_en,
                               input logic [4:0] rd2, input logic rd2_en,
                               input logic exp_ready,
                               input logic [31:0] exp_op1, input logic [31:0] exp_op2);
    rec_t r;
    in_valid_i = 1'b1;
    rs1_i = rs1; rs1_en_i = rs1_en; rs2_i = rs2; rs2_en_i = rs2_en;
    rd_i = rd; rd_en_i = rd_en; rd2_i = rd2; rd2_en_i = rd2_en;
    @(negedge clk);
    checkOutput("in_ready", {75'd0, in_ready_o}, {75'd0, exp_ready});
    if (exp_ready) begin
      r = '{op1: exp_op1, op2: exp_op2, rd: rd, rd2: rd2, rd_en: rd_en, rd2_en: rd2_en};
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    setWb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic idleCycle();
    in_valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    for (int r = 0; r < 32; r++) gr_mem[r] = 32'h1000_0000 + 32'(r);
    gr_mem[0] = 32'd0;
    gr_mem[3] = 32'h11;
    gr_mem[4] = 32'h22;
    rst_n = 1'b0; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    rs1_i = '0; rs2_i = '0; rd_i = '0; rd2_i = '0;
    rs1_en_i = 1'b0; rs2_en_i = 1'b0; rd_en_i = 1'b0; rd2_en_i = 1'b0;
    setWb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    #12;
    checkOutput("reset_valid", {75'd0, out_valid_o}, 76'd0);
    checkOutput("reset_ops", {12'd0, op1_o, op2_o}, 76'd0);
    checkOutput("reset_rds", {64'd0, out_rd_o, out_rd2_o, out_rd_en_o, out_rd2_en_o}, 76'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", {75'd0, in_ready_o}, 76'd1);
    @(posedge clk);
    #1;

    // Plain read, then RAW on a handed-off destination released by writeback.
    applyStimulus(5'd3, 1, 5'd4, 1, 5'd0, 0, 5'd0, 0, 1, 32'h11, 32'h22);
    applyStimulus(5'd5, 0, 5'd0, 0, 5'd5, 1, 5'd0, 0, 1, 32'h0, 32'h0);
    applyStimulus(5'd5, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 32'h0, 32'h0);
    applyStimulus(5'd5, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 32'h0, 32'h0);
    setWb(1'b1, 5'd5, 32'hABCD, 1'b0, 5'd0, 32'd0);
    applyStimulus(5'd5, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 32'hABCD, 32'h0);
    applyStimulus(5'd5, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 32'hABCD, 32'h0);

    // Dual writeback to one register: port 2 wins.
    setWb(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2);
    applyStimulus(5'd7, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 32'h2, 32'h0);

    // r0 as source and destination never stalls.
    applyStimulus(5'd0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 1, 32'h0, 32'h0);
    applyStimulus(5'd0, 1, 5'd0, 0, 5'd0, 1, 5'd0, 1, 1, 32'h0, 32'h0);

    // RAW on rs2 against rd2, released by writeback port 2 with forwarding.
    applyStimulus(5'd0, 0, 5'd0, 0, 5'd0, 0, 5'd20, 1, 1, 32'h0, 32'h0);
    applyStimulus(5'd1, 1, 5'd20, 1, 5'd0, 0, 5'd0, 0, 0, 32'h0, 32'h0);
    setWb(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h55);
    applyStimulus(5'd1, 1, 5'd20, 1, 5'd0, 0, 5'd0, 0, 1, 32'h1000_0001, 32'h55);
    idleCycle();

    // Back-pressure hold, then flush of the held instruction.
    out_ready_i = 1'b0;
    applyStimulus(5'd3, 1, 5'd4, 1, 5'd12, 1, 5'd0, 0, 1, 32'h11, 32'h22);
    for (int i = 0; i < 3; i++)
      applyStimulus(5'd1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 32'h0, 32'h0);
    flush_i = 1'b1;
    applyStimulus(5'd1, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 32'h0, 32'h0);
    flush_i = 1'b0;
    checkOutput("valid_after_flush", {75'd0, out_valid_o}, 76'd0);
    out_ready_i = 1'b1;
    applyStimulus(5'd12, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 32'h1000_000C, 32'h0);
    idleCycle();

    // WAW on r9 until writeback retires it.
    applyStimulus(5'd0, 0, 5'd0, 0, 5'd9, 1, 5'd0, 0, 1, 32'h0, 32'h0);
    applyStimulus(5'd0, 0, 5'd0, 0, 5'd9, 1, 5'd0, 0, 0, 32'h0, 32'h0);
    applyStimulus(5'd0, 0, 5'd0, 0, 5'd9, 1, 5'd0, 0, 0, 32'h0, 32'h0);
    setWb(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
    applyStimulus(5'd0, 0, 5'd0, 0, 5'd9, 1, 5'd0, 0, 1, 32'h0, 32'h0);
    applyStimulus(5'd3, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 32'h11, 32'h0);
    out_ready_i = 1'b0;
    applyStimulus(5'd0, 0, 5'd0, 0, 5'd9, 1, 5'd0, 0, 0, 32'h0, 32'h0);

    // Asynchronous reset in the middle of the stall.
    in_valid_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", {75'd0, out_valid_o}, 76'd0);
    checkOutput("async_reset_ops", {12'd0, op1_o, op2_o}, 76'd0);
    checkOutput("async_reset_rds", {64'd0, out_rd_o, out_rd2_o, out_rd_en_o, out_rd2_en_o}, 76'd0);
    exp_q.delete();
    in_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    applyStimulus(5'd0, 0, 5'd0, 0, 5'd9, 1, 5'd0, 0, 1, 32'h0, 32'h0);
    idleCycle();
    idleCycle();
    checkOutput("queue_drained", 76'(exp_q.size()), 76'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read stage sitting between decode and execute; it is the reader-side counterpart of the writeback stage that updates the general register file GR. It captures up to two source operands per instruction from GR, forwards same-cycle writeback results, and tracks in-flight destinations in a 31-entry scoreboard. Instructions with RAW or WAW hazards are stalled until the producing result retires. One instruction enters per cycle, with a single output register toward execute.

## Interface
- No parameters. Fixed: 32 registers × 32 bits; r0 reads as zero.
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- gr_i  in  32×32  architectural register values; a write presented on the wb ports appears here from the next edge
- in_valid_i  in  1  decode presents an instruction
- in_ready_o  out  1  stage accepts this cycle
- rs1_i, rs2_i  in  5  source register indices
- rs1_en_i, rs2_en_i  in  1  source actually used
- rd_i, rd2_i  in  5  destination indices (rd2 for dual-result ops)
- rd_en_i, rd2_en_i  in  1  destination written
- wb_en_i, wb2_en_i  in  1  writeback port 1/2 retiring a result
- wb_dest_i, wb2_dest_i  in  5  retiring destination
- wb_data_i, wb2_data_i  in  32  retiring value
- flush_i  in  1  discard the output register and refuse input this cycle
- out_valid_o  out  1  operands valid toward execute
- out_ready_i  in  1  execute accepts
- op1_o, op2_o  out  32  fetched operands (0 when the source is disabled)
- out_rd_o, out_rd2_o  out  5  passed-through destinations
- out_rd_en_o, out_rd2_en_o  out  1  passed-through destination enables

## Operation
- Scoreboard: pending[31:1]. A bit is set when an instruction with that enabled destination hands off (out_valid_o && out_ready_i). It is cleared when a wb port with that destination is enabled. Clear and set of the same bit on the same edge leaves the bit set. r0 is never pending.
- busy[r] = pending[r] | (out_valid_o && an enabled out destination == r).
- retiring[r] = (wb_en_i && wb_dest_i == r) | (wb2_en_i && wb2_dest_i == r).
- RAW hazard: an enabled source r != 0 with busy[r] && !(pending[r] && retiring[r]).
- WAW hazard: an enabled destination r != 0 with busy[r] && !(pending[r] && retiring[r]).
- in_ready_o = (!out_valid_o || out_ready_i) && !hazard && !flush_i. This is combinational from the rs/rd inputs, so upstream holds them stable while in_valid_i is high.
- Operand select per source, in priority order: disabled or r0 → 0; wb2 port hit → wb2_data_i; wb port hit → wb_data_i; otherwise gr_i[r]. Port 2 wins over port 1, matching the writeback stage's write order.
- A wb port retiring to a non-pending register has no scoreboard effect.
- flush_i clears out_valid_o on the next edge. The flushed instruction never hands off, so its destinations never become pending. Pending bits of already-handed-off instructions are untouched.

## Timing
- Reset values: out_valid_o 0, op1_o/op2_o 0, all out_rd* 0, pending all 0. in_ready_o becomes 1 once reset is released, provided flush_i is low.
- Latency: accept at edge N → out_valid_o high after edge N; throughput 1 per cycle with out_ready_i held high.
- The output register holds all fields stable while out_valid_o && !out_ready_i.
- Hand-off and accept on the same edge are allowed. The outgoing instruction's destinations are counted through busy in that cycle's hazard check.
- Reset asserted mid-stall discards the held instruction and clears the scoreboard.

## Test plan
- Reset, then accept rs1=3, rs2=4 with gr_i[3]=0x11, gr_i[4]=0x22 → one cycle later out_valid_o=1, op1_o=0x11, op2_o=0x22.
- Hand off rd=5, then present rs1=5 → in_ready_o=0. Assert wb_en_i with dest 5, data 0xABCD → accepted that cycle, op1_o=0xABCD next cycle, pending[5]=0.
- Both wb ports retire dest 7 in the same cycle (0x1 on port 1, 0x2 on port 2) while rs1=7 is accepted → op1_o=0x2.
- Source r0 with rs1_en_i=1, or rd=0, → op1_o=0, no stall, no pending bit set.
- Hold out_ready_i=0 for 3 cycles → outputs stable and in_ready_o=0. Assert flush_i → out_valid_o=0 next cycle, no pending bit set.
- Back-to-back rd=9 then rd=9 → second stalls (WAW) until wb retires 9. Assert rst_n=0 mid-stall → all outputs 0 asynchronously.
